// File: rtl/ctrl_opcode_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_opcode_encoder
//  Description : Re-encodes a 7-bit control bundle into the 3-bit main-decoder
//                opcode, buffers legal opcodes in a valid/ready FIFO and counts
//                illegal bundles.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_opcode_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               in_ctrl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_op,
  output logic                     err,
  output logic [CNT_W-1:0]         err_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LVL_W  = ADDR_W + 1;

  localparam logic [6:0] c_CTRL_RTYPE = 7'b1100000;
  localparam logic [6:0] c_CTRL_LW    = 7'b0111100;
  localparam logic [6:0] c_CTRL_SW    = 7'b0011010;
  localparam logic [6:0] c_CTRL_BEQ   = 7'b0000001;

  localparam logic [2:0] c_OP_RTYPE = 3'b000;
  localparam logic [2:0] c_OP_LW    = 3'b100;
  localparam logic [2:0] c_OP_SW    = 3'b010;
  localparam logic [2:0] c_OP_BEQ   = 3'b110;

  logic [2:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_err;
  logic [CNT_W-1:0]  r_err_count;

  logic       w_legal;
  logic [2:0] w_op;
  logic       w_accept;
  logic       w_push;
  logic       w_pop;
  logic       w_illegal;

  // Exact-match encode; anything outside the four bundles is illegal.
  always_comb begin
    w_legal = 1'b1;
    w_op    = c_OP_RTYPE;
    case (in_ctrl)
      c_CTRL_RTYPE: w_op = c_OP_RTYPE;
      c_CTRL_LW:    w_op = c_OP_LW;
      c_CTRL_SW:    w_op = c_OP_SW;
      c_CTRL_BEQ:   w_op = c_OP_BEQ;
      default:      w_legal = 1'b0;
    endcase
  end

  assign in_ready  = (r_level != LVL_W'(DEPTH));
  assign out_valid = (r_level != '0);
  assign out_op    = out_valid ? r_mem[r_rd_ptr] : 3'b000;
  assign level     = r_level;
  assign err       = r_err;
  assign err_count = r_err_count;

  assign w_accept  = in_valid && in_ready;
  assign w_push    = w_accept && w_legal;
  assign w_illegal = w_accept && !w_legal;
  assign w_pop     = out_valid && out_ready;

  // Storage needs no reset: out_op is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err <= w_illegal;
      if (w_illegal && (r_err_count != {CNT_W{1'b1}})) begin
        r_err_count <= r_err_count + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_opcode_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_opcode_encoder
//  Description : Directed and randomized bench for ctrl_opcode_encoder with a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_opcode_encoder;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_ctrl;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_op;
  logic       err;
  logic [7:0] err_count;
  logic [2:0] level;

  logic       s_in_valid;
  logic       s_in_ready;
  logic [6:0] s_in_ctrl;
  logic       s_out_valid;
  logic [2:0] s_out_op;
  logic       s_err;
  logic [1:0] s_err_count;
  logic [2:0] s_level;

  ctrl_opcode_encoder #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .err(err), .err_count(err_count), .level(level)
  );

  ctrl_opcode_encoder #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ctrl(s_in_ctrl),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_op(s_out_op),
    .err(s_err), .err_count(s_err_count), .level(s_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the opcode table plus a queue of pending opcodes.
  logic [6:0] c_codes [4] = '{7'b1100000, 7'b0111100, 7'b0011010, 7'b0000001};
  logic [2:0] c_ops   [4] = '{3'b000, 3'b100, 3'b010, 3'b110};
  logic [2:0] mq [$];
  int         m_cnt;
  logic       m_err;

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int lookup(input logic [6:0] c);
    for (int i = 0; i < 4; i++) if (c_codes[i] == c) return i;
    return -1;
  endfunction

  // One clock cycle: drive, check pre-edge outputs, clock, update model, check err.
  task automatic step(input logic v, input logic [6:0] c, input logic r);
    int  idx;
    bit  acc;
    @(negedge clk);
    in_valid  = v;
    in_ctrl   = c;
    out_ready = r;
    #1;
    check("in_ready",  32'(in_ready),  32'(mq.size() != DEPTH));
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("out_op",    32'(out_op),    (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    check("level",     32'(level),     32'(mq.size()));
    acc = v && (mq.size() != DEPTH);
    idx = lookup(c);
    @(posedge clk);
    if (r && mq.size() != 0) void'(mq.pop_front());
    m_err = acc && (idx < 0);
    if (acc && idx >= 0) mq.push_back(c_ops[idx]);
    if (m_err && m_cnt < 255) m_cnt++;
    #1;
    check("err",       32'(err),       32'(m_err));
    check("err_count", 32'(err_count), 32'(m_cnt));
  endtask

  function automatic logic [6:0] rand_ctrl();
    if ($urandom_range(3) != 0) return c_codes[$urandom_range(3)];
    return 7'($urandom);
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_ctrl = '0;
    m_cnt = 0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_op",    32'(out_op),    32'd0);
    check("rst_err",       32'(err),       32'd0);
    @(negedge clk);
    rst = 1'b0;

    // All four encodings, drained as they arrive.
    for (int i = 0; i < 4; i++) step(1'b1, c_codes[i], 1'b1);
    repeat (2) step(1'b0, 7'd0, 1'b1);

    // Fill past full under backpressure, then drain.
    for (int i = 0; i < 5; i++) step(1'b1, c_codes[i % 4], 1'b0);
    repeat (5) step(1'b0, 7'd0, 1'b1);

    // Illegal bundle sandwiched between two LWs.
    step(1'b1, 7'b0111100, 1'b0);
    step(1'b1, 7'b1111111, 1'b0);
    step(1'b1, 7'b0111100, 1'b0);
    check("illegal_one", 32'(m_cnt), 32'd1);
    repeat (3) step(1'b0, 7'd0, 1'b1);

    // Asynchronous reset mid-stream at level 3.
    repeat (3) step(1'b1, c_codes[1], 1'b0);
    check("pre_rst_level", 32'(level), 32'd3);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_level",     32'(level),     32'd0);
    check("arst_err_count", 32'(err_count), 32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_out_op",    32'(out_op),    32'd0);
    mq.delete(); m_cnt = 0; m_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Concurrent push+pop at level 2 across pointer wrap.
    step(1'b1, c_codes[2], 1'b0);
    step(1'b1, c_codes[3], 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, c_codes[$urandom_range(3)], 1'b1);
    check("concurrent_level", 32'(level), 32'd2);
    repeat (3) step(1'b0, 7'd0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) step(1'($urandom), rand_ctrl(), 1'($urandom));
    repeat (5) step(1'b0, 7'd0, 1'b1);

    // Saturating counter on the narrow instance.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_in_valid = 1'b1;
      s_in_ctrl  = 7'b1111111;
      @(posedge clk);
      #1;
      check("sat_err",   32'(s_err),       32'd1);
      check("sat_count", 32'(s_err_count), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    @(negedge clk);
    s_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("sat_err_clear", 32'(s_err),       32'd0);
    check("sat_hold",      32'(s_err_count), 32'd3);
    check("sat_level",     32'(s_level),     32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
